// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the MEM-stage LSU (master) and data memory (slave):
// valid/ready request channel plus an rvalid read-response channel.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              rvalid;
  logic [63:0]       rdata;

  modport master (
    output req_valid, we, addr, wdata, wstrb,
    input  req_ready, rvalid, rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata, wstrb,
    output req_ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per EX/MEM instruction,
// stalls the pipeline until it completes, and flags misaligned/illegal accesses.
module mem_stage_lsu #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_alu_result,
  input  logic [63:0]       i_rs2_val,
  input  logic [2:0]        i_funct3,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  output logic              o_stall,
  output logic [63:0]       o_load_data,
  output logic              o_exc,
  output logic [CNT_W-1:0]  o_stall_cnt,
  mem_stage_lsu_if.master   dmem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wstrb;
  logic [63:0]       r_load_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_access;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_start;
  logic [2:0]        w_off;
  logic [7:0]        w_strb_base;
  logic [7:0]        w_wstrb;
  logic [63:0]       w_wdata;
  logic [63:0]       w_lane;
  logic [63:0]       w_load_ext;

  assign w_access = i_mem_read | i_mem_write;
  assign w_off    = i_alu_result[2:0];

  always_comb begin
    w_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = |w_off[1:0];
      2'b11:   w_misalign = |w_off;
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_illegal = (i_mem_read & i_mem_write)
                   | (i_mem_read & (i_funct3 == 3'b111))
                   | (i_mem_write & i_funct3[2])
                   | w_misalign;
  assign o_exc   = (r_state == IDLE) & w_access & w_illegal;
  assign w_start = (r_state == IDLE) & w_access & ~w_illegal;

  always_comb begin
    w_strb_base = 8'h00;
    case (i_funct3[1:0])
      2'b00:   w_strb_base = 8'h01;
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
  end

  // Alignment is already guaranteed for a started access, so the shift never drops lanes.
  assign w_wstrb = i_mem_write ? (w_strb_base << w_off) : 8'h00;
  assign w_wdata = i_rs2_val << {w_off, 3'b000};

  assign w_lane = dmem.rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (r_funct3)
      3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load_ext = {56'b0, w_lane[7:0]};
      3'b101:  w_load_ext = {48'b0, w_lane[15:0]};
      3'b110:  w_load_ext = {32'b0, w_lane[31:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    o_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next  = REQ;
          o_stall = 1'b1;
        end
      end
      REQ: begin
        o_stall = 1'b1;
        if (dmem.req_ready) w_next = r_we ? DONE : RESP;
      end
      RESP: begin
        o_stall = 1'b1;
        if (dmem.rvalid) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_load_data <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr   <= i_alu_result;
        r_funct3 <= i_funct3;
        r_we     <= i_mem_write;
        r_wdata  <= w_wdata;
        r_wstrb  <= w_wstrb;
      end
      if ((r_state == RESP) && dmem.rvalid) r_load_data <= w_load_ext;
      if (o_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign dmem.req_valid = (r_state == REQ);
  assign dmem.we        = r_we;
  assign dmem.addr      = {r_addr[ADDR_W-1:3], 3'b000};
  assign dmem.wdata     = r_wdata;
  assign dmem.wstrb     = r_wstrb;
  assign o_load_data    = r_load_data;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized loads/stores
// checked against a byte-level reference model and a modelled stall counter.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_alu_result;
  logic [63:0] i_rs2_val;
  logic [2:0]  i_funct3;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        o_stall;
  logic [63:0] o_load_data;
  logic        o_exc;
  logic [31:0] o_stall_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] modelCnt = '0;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_W(64)) dmem ();

  mem_stage_lsu #(.ADDR_W(64), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_alu_result (i_alu_result),
    .i_rs2_val    (i_rs2_val),
    .i_funct3     (i_funct3),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .o_stall      (o_stall),
    .o_load_data  (o_load_data),
    .o_exc        (o_exc),
    .o_stall_cnt  (o_stall_cnt),
    .dmem         (dmem)
  );

  // Reference model: access size in bytes, lane-by-lane extraction and arithmetic sign extension.
  function automatic int accBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] modelLoad(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] rd);
    int          n = accBytes(f3);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(off)+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  function automatic logic [7:0] modelStrb(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] s = '0;
    for (int i = 0; i < accBytes(f3); i++) s[int'(off)+i] = 1'b1;
    return s;
  endfunction

  task automatic doAccess(input string name, input bit isLoad, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] val, input logic [63:0] rdata,
                          input int rdyDelay, input int rvDelay);
    logic [63:0] expAddr  = {addr[63:3], 3'b000};
    logic [7:0]  expStrb  = isLoad ? 8'h00 : modelStrb(f3, addr[2:0]);
    logic [63:0] expWdata = val << (8*int'(addr[2:0]));
    logic [63:0] expLoad  = modelLoad(f3, addr[2:0], rdata);
    int          expStall = 2 + rdyDelay + (isLoad ? rvDelay + 1 : 0);
    int          cyc = 0, reqCyc = 0, respCyc = 0, stallCyc = 0;
    bit          inResp = 0, done = 0;
    i_alu_result = addr;
    i_rs2_val    = val;
    i_funct3     = f3;
    i_mem_read   = isLoad;
    i_mem_write  = !isLoad;
    while (!done && cyc < 60) begin
      @(negedge clk);
      dmem.req_ready = dmem.req_valid && (reqCyc >= rdyDelay);
      dmem.rvalid    = inResp && (respCyc == rvDelay);
      dmem.rdata     = dmem.rvalid ? rdata : {$urandom, $urandom};
      #1;
      if (cyc == 0) begin
        checks++;
        if (o_stall !== 1'b1 || o_exc !== 1'b0 || dmem.req_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s start: stall=%b exc=%b req_valid=%b, required 1 0 0", name, o_stall, o_exc, dmem.req_valid);
        end
      end
      if (dmem.req_valid) begin
        checks++;
        if (dmem.addr !== expAddr || dmem.we !== !isLoad || dmem.wstrb !== expStrb ||
            (!isLoad && dmem.wdata !== expWdata)) begin
          failures++;
          $display("FAIL %s request: addr=%h we=%b wstrb=%h wdata=%h, required addr=%h we=%b wstrb=%h wdata=%h",
                   name, dmem.addr, dmem.we, dmem.wstrb, dmem.wdata, expAddr, !isLoad, expStrb, expWdata);
        end
        reqCyc++;
        if (dmem.req_ready) inResp = isLoad;
      end else if (inResp) begin
        if (dmem.rvalid) inResp = 0;
        respCyc++;
      end
      if (o_stall) stallCyc++;
      else done = 1;
      cyc++;
    end
    dmem.req_ready = 1'b0;
    dmem.rvalid    = 1'b0;
    modelCnt       = modelCnt + 32'(expStall);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: no DONE within %0d cycles", name, cyc);
    end
    checks++;
    if (stallCyc != expStall || o_stall_cnt !== modelCnt) begin
      failures++;
      $display("FAIL %s stall: cycles=%0d cnt=%0d, required cycles=%0d cnt=%0d", name, stallCyc, o_stall_cnt, expStall, modelCnt);
    end
    if (isLoad) begin
      checks++;
      if (o_load_data !== expLoad) begin
        failures++;
        $display("FAIL %s load_data: got %h required %h", name, o_load_data, expLoad);
      end
    end
    @(posedge clk);
    #1;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_alu_result = '0; i_rs2_val = '0; i_funct3 = '0; i_mem_read = 0; i_mem_write = 0;
    dmem.req_ready = 0; dmem.rvalid = 0; dmem.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dmem.req_valid !== 0 || dmem.we !== 0 || dmem.addr !== '0 || dmem.wdata !== '0 ||
        dmem.wstrb !== '0 || o_load_data !== '0 || o_stall_cnt !== '0 || o_stall !== 0) begin
      failures++;
      $display("FAIL reset_values: req_valid=%b we=%b addr=%h wstrb=%h load=%h cnt=%0d stall=%b, required all 0",
               dmem.req_valid, dmem.we, dmem.addr, dmem.wstrb, o_load_data, o_stall_cnt, o_stall);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_word();
    doAccess("lw_0x1004", 1, 3'b010, 64'h1004, 64'h0, 64'hDEADBEEF_80000001, 0, 0);
  endtask

  task automatic test_store_byte();
    doAccess("sb_0x2003", 0, 3'b000, 64'h2003, 64'hAB, 64'h0, 0, 0);
  endtask

  task automatic test_lbu_wait();
    doAccess("lbu_0x3007", 1, 3'b100, 64'h3007, 64'h0, 64'h80FF_0000_0000_0000, 4, 0);
  endtask

  task automatic test_exceptions();
    logic [2:0]  f3s [6] = '{3'b010, 3'b011, 3'b111, 3'b100, 3'b001, 3'b010};
    logic [63:0] ads [6] = '{64'h1002, 64'h1004, 64'h1000, 64'h1000, 64'h1001, 64'h1000};
    bit          rds [6] = '{1, 0, 1, 0, 1, 1};
    bit          wrs [6] = '{0, 1, 0, 1, 0, 1};
    for (int k = 0; k < 6; k++) begin
      i_alu_result = ads[k]; i_funct3 = f3s[k]; i_mem_read = rds[k]; i_mem_write = wrs[k];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (o_exc !== 1'b1 || o_stall !== 1'b0 || dmem.req_valid !== 1'b0 || o_stall_cnt !== modelCnt) begin
          failures++;
          $display("FAIL exc_case%0d: exc=%b stall=%b req_valid=%b cnt=%0d, required 1 0 0 cnt=%0d",
                   k, o_exc, o_stall, dmem.req_valid, o_stall_cnt, modelCnt);
        end
      end
      @(posedge clk);
      #1;
    end
    i_mem_read = 0; i_mem_write = 0;
    #1;
    checks++;
    if (o_exc !== 1'b0) begin
      failures++;
      $display("FAIL exc_idle: got %b required 0", o_exc);
    end
  endtask

  task automatic test_back_to_back();
    doAccess("ld_0x8", 1, 3'b011, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1);
    doAccess("sh_0xA", 0, 3'b001, 64'hA, 64'h1234, 64'h0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit          isLoad = 1'($urandom_range(0, 1));
      logic [2:0]  f3     = isLoad ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      int          nb     = accBytes(f3);
      logic [63:0] addr   = {$urandom, $urandom};
      addr[2:0] = 3'(nb * $urandom_range(0, 8 / nb - 1));
      doAccess($sformatf("rand%0d", n), isLoad, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_access();
    i_alu_result = 64'h1000; i_funct3 = 3'b010; i_mem_read = 1; i_mem_write = 0;
    dmem.req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmem.req_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dmem.req_valid !== 0 || dmem.addr !== '0 || dmem.we !== 0 || dmem.wstrb !== '0 ||
        dmem.wdata !== '0 || o_load_data !== '0 || o_stall_cnt !== '0) begin
      failures++;
      $display("FAIL async_reset: req_valid=%b addr=%h load=%h cnt=%0d, required all 0",
               dmem.req_valid, dmem.addr, o_load_data, o_stall_cnt);
    end
    i_mem_read = 0;
    modelCnt   = '0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b required 0", o_stall);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    dmem.rvalid = 1'b1; dmem.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    checks++;
    if (o_load_data !== '0 || o_stall !== 0 || dmem.req_valid !== 0 || o_stall_cnt !== '0) begin
      failures++;
      $display("FAIL stray_rvalid: load=%h stall=%b req_valid=%b cnt=%0d, required 0 0 0 0",
               o_load_data, o_stall, dmem.req_valid, o_stall_cnt);
    end
    doAccess("sw_after_reset", 0, 3'b010, 64'h44, 64'hCAFE_F00D, 64'h0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_lbu_wait();
    test_exceptions();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
